sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo_param.sv | 137 +++++++++++++
 tb/tb_sync_fifo_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO.
//   FIFO_MODE_STD  : registered read, rd_valid pulses one cycle after a pop
//   FIFO_MODE_FWFT : first-word-fall-through, head word shown while non-empty
//   fifo_cnt_w()   : width of an occupancy counter able to hold 0..depth
package sync_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x DATA_W, synchronous write, asynchronous read.
// Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with standard or first-word-fall-through read,
// threshold flags and sticky overflow/underflow error flags.
//   clk, rstn          : clock, asynchronous active-low reset
//   cs                 : chip select; gates push, pop and error detection
//   flush              : synchronous clear of pointers/count (memory untouched)
//   wr_en, wr_data     : push request and data
//   rd_en              : pop request
//   rd_data, rd_valid  : read data and qualifier
//   full, empty        : occupancy == DEPTH / == 0
//   almost_full/empty  : count >= AF_THRESH / count <= AE_THRESH
//   count              : current occupancy
//   overflow/underflow : sticky error flags, cleared by clr_err
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FWFT      = FIFO_MODE_STD,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cs,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int unsigned CNT_W = fifo_cnt_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] head;
    logic              pop_ok, push_ok, mem_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags decode registered count only.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign pop_ok  = cs && rd_en && !empty;
    // A pop in the same cycle frees the slot this push needs.
    assign push_ok = cs && wr_en && (!full || pop_ok);
    assign mem_we  = push_ok && !flush;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = (overflow_q  && !clr_err) || (cs && wr_en && full && !pop_ok);
        underflow_d = (underflow_q && !clr_err) || (cs && rd_en && empty);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
            if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

            if (FWFT == FIFO_MODE_FWFT) begin
                // Remember the last shown head so rd_data holds once empty.
                if (!empty) rd_data_d = head;
            end else begin
                rd_valid_d = pop_ok;
                if (pop_ok) rd_data_d = head;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_valid = (FWFT == FIFO_MODE_FWFT) ? !empty : rd_valid_q;
    assign rd_data  = ((FWFT == FIFO_MODE_FWFT) && !empty) ? head : rd_data_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance (DEPTH=5,
// AF_THRESH=4, AE_THRESH=1) share all inputs and are checked against a
// queue-based reference model.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rstn, cs, flush, wr_en, rd_en, clr_err;
    logic [15:0] wr_data;

    logic [15:0] s_rd_data, f_rd_data;
    logic        s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic        f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  s_count, f_count;
    logic [9:0]  st_std, st_fwft;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] m_rd;
    logic        m_rv, m_ovf, m_unf;

    localparam logic [9:0] RST_ST = {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W (16), .DEPTH (5), .FWFT (0), .AF_THRESH (4), .AE_THRESH (1)
    ) dut_std (
        .clk (clk), .rstn (rstn), .cs (cs), .flush (flush), .wr_en (wr_en),
        .wr_data (wr_data), .rd_en (rd_en), .rd_data (s_rd_data), .rd_valid (s_rv),
        .full (s_full), .empty (s_empty), .almost_full (s_af), .almost_empty (s_ae),
        .count (s_count), .overflow (s_ovf), .underflow (s_unf), .clr_err (clr_err)
    );

    sync_fifo_param #(
        .DATA_W (16), .DEPTH (5), .FWFT (1), .AF_THRESH (4), .AE_THRESH (1)
    ) dut_fwft (
        .clk (clk), .rstn (rstn), .cs (cs), .flush (flush), .wr_en (wr_en),
        .wr_data (wr_data), .rd_en (rd_en), .rd_data (f_rd_data), .rd_valid (f_rv),
        .full (f_full), .empty (f_empty), .almost_full (f_af), .almost_empty (f_ae),
        .count (f_count), .overflow (f_ovf), .underflow (f_unf), .clr_err (clr_err)
    );

    assign st_std  = {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rv};
    assign st_fwft = {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_rv};

    function automatic logic [9:0] exp_status(input logic rv);
        int n = q.size();
        return {3'(n), n == 5, n == 0, n >= 4, n <= 1, m_ovf, m_unf, rv};
    endfunction

    task automatic model_reset();
        q.delete();
        m_rd  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of FIFO behaviour from the interface rules.
    task automatic model_step();
        bit pop_ok  = cs && rd_en && (q.size() != 0);
        bit push_ok = cs && wr_en && ((q.size() < 5) || pop_ok);
        bit ovf_set = cs && wr_en && (q.size() == 5) && !pop_ok;
        bit unf_set = cs && rd_en && (q.size() == 0);
        m_ovf = (m_ovf && !clr_err) || ovf_set;
        m_unf = (m_unf && !clr_err) || unf_set;
        if (flush) begin
            q.delete();
            m_rv = 1'b0;
        end else begin
            m_rv = pop_ok;
            if (pop_ok)  m_rd = q.pop_front();
            if (push_ok) q.push_back(wr_data);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [15:0] d,
                        input logic f, input logic ce);
        cs = c; wr_en = w; rd_en = r; wr_data = d; flush = f; clr_err = ce;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cs = 0; wr_en = 0; rd_en = 0; wr_data = '0; flush = 0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (st_std !== RST_ST) begin
            failures++; $display("FAIL reset_std_status: got %b expected %b", st_std, RST_ST);
        end
        checks++;
        if (st_fwft !== RST_ST) begin
            failures++; $display("FAIL reset_fwft_status: got %b expected %b", st_fwft, RST_ST);
        end
        checks++;
        if (s_rd_data !== 16'h0000 || f_rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rd_data: got %h/%h expected 0000", s_rd_data, f_rd_data);
        end
        rstn = 1'b1;
        step(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, 0, 16'(i), 0, 0);
            checks++;
            if (st_std !== exp_status(m_rv)) begin
                failures++; $display("FAIL fill_status: got %b expected %b", st_std, exp_status(m_rv));
            end
        end
        checks++;
        if (s_full !== 1'b1 || s_count !== 3'd5) begin
            failures++; $display("FAIL fill_full: got full=%b count=%0d expected 1/5", s_full, s_count);
        end
        step(1, 1, 0, 16'h0006, 0, 0);
        checks++;
        if (s_ovf !== 1'b1 || s_count !== 3'd5 || f_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_push: got ovf=%b/%b count=%0d expected 1/1/5", s_ovf, f_ovf, s_count);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 1, '0, 0, 0);
            checks++;
            if (s_rv !== 1'b1 || s_rd_data !== 16'(i)) begin
                failures++;
                $display("FAIL pop_data: got rv=%b data=%h expected 1/%h", s_rv, s_rd_data, 16'(i));
            end
        end
        step(0, 0, 0, '0, 0, 1);
        checks++;
        if (s_empty !== 1'b1 || s_rv !== 1'b0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL drained: got empty=%b rv=%b ovf=%b expected 1/0/0", s_empty, s_rv, s_ovf);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) step(1, 1, 0, 16'($urandom), 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 16'($urandom), 0, 0);
            checks++;
            if (s_rd_data !== m_rd || st_std !== exp_status(m_rv)) begin
                failures++;
                $display("FAIL wrap_std: got %h/%b expected %h/%b", s_rd_data, st_std, m_rd, exp_status(m_rv));
            end
            checks++;
            if (f_rv !== 1'b1 || f_rd_data !== q[0]) begin
                failures++; $display("FAIL wrap_fwft: got %b/%h expected 1/%h", f_rv, f_rd_data, q[0]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1, '0, 0, 0);
            checks++;
            if (s_rd_data !== m_rd) begin
                failures++; $display("FAIL wrap_drain: got %h expected %h", s_rd_data, m_rd);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 16'($urandom), 0, 0);
        step(1, 1, 1, 16'hAAAA, 0, 0);
        checks++;
        if (s_count !== 3'd5 || s_ovf !== 1'b0) begin
            failures++; $display("FAIL full_push_pop: got count=%0d ovf=%b expected 5/0", s_count, s_ovf);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 1, '0, 0, 0);
        checks++;
        if (s_rd_data !== 16'hAAAA) begin
            failures++; $display("FAIL full_push_pop_last: got %h expected aaaa", s_rd_data);
        end
        step(1, 1, 1, 16'h1234, 0, 0);
        checks++;
        if (s_unf !== 1'b1 || s_count !== 3'd1) begin
            failures++; $display("FAIL empty_push_pop: got unf=%b count=%0d expected 1/1", s_unf, s_count);
        end
        step(1, 0, 1, '0, 0, 1);
        checks++;
        if (s_rd_data !== 16'h1234 || s_unf !== 1'b0) begin
            failures++; $display("FAIL empty_push_pop_read: got %h unf=%b expected 1234/0", s_rd_data, s_unf);
        end
    endtask

    task automatic test_fwft();
        step(1, 1, 0, 16'hBEEF, 0, 0);
        checks++;
        if (f_rv !== 1'b1 || f_rd_data !== 16'hBEEF) begin
            failures++; $display("FAIL fwft_show: got %b/%h expected 1/beef", f_rv, f_rd_data);
        end
        checks++;
        if (s_rv !== 1'b0) begin
            failures++; $display("FAIL std_no_early: got rv=%b expected 0", s_rv);
        end
        step(1, 0, 1, '0, 0, 0);
        checks++;
        if (f_rv !== 1'b0 || s_rv !== 1'b1 || s_rd_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL fwft_pop: got frv=%b srv=%b sdata=%h expected 0/1/beef", f_rv, s_rv, s_rd_data);
        end
    endtask

    task automatic test_thresholds();
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (s_ae !== (i <= 1) || s_af !== (i >= 4) || f_ae !== (i <= 1) || f_af !== (i >= 4)) begin
                failures++;
                $display("FAIL thresh_cnt%0d: got ae=%b af=%b expected %b %b", i, s_ae, s_af, i <= 1, i >= 4);
            end
            if (i < 5) step(1, 1, 0, 16'($urandom), 0, 0);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 1, '0, 0, 0);
    endtask

    task automatic test_flush();
        logic [15:0] held;
        step(1, 0, 1, '0, 0, 0);                      // underflow to show flush leaves it
        for (int i = 0; i < 3; i++) step(1, 1, 0, 16'($urandom), 0, 0);
        held = m_rd;
        step(1, 1, 1, 16'h7777, 1, 0);
        checks++;
        if (s_count !== 3'd0 || s_empty !== 1'b1 || s_rv !== 1'b0 || f_rv !== 1'b0) begin
            failures++;
            $display("FAIL flush: got count=%0d empty=%b rv=%b/%b expected 0/1/0/0", s_count, s_empty, s_rv, f_rv);
        end
        checks++;
        if (s_rd_data !== held || s_unf !== 1'b1) begin
            failures++; $display("FAIL flush_hold: got %h unf=%b expected %h/1", s_rd_data, s_unf, held);
        end
        step(1, 1, 0, 16'hC3C3, 0, 1);
        step(1, 0, 1, '0, 0, 0);
        checks++;
        if (s_rd_data !== 16'hC3C3 || s_empty !== 1'b1) begin
            failures++; $display("FAIL flush_after: got %h empty=%b expected c3c3/1", s_rd_data, s_empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 16'($urandom),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0);
            checks++;
            if (st_std !== exp_status(m_rv) || s_rd_data !== m_rd) begin
                failures++;
                $display("FAIL rand_std: got %b/%h expected %b/%h", st_std, s_rd_data, exp_status(m_rv), m_rd);
            end
            checks++;
            if (st_fwft !== exp_status(q.size() != 0) || (q.size() != 0 && f_rd_data !== q[0])) begin
                failures++;
                $display("FAIL rand_fwft: got %b/%h expected %b", st_fwft, f_rd_data, exp_status(q.size() != 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 16'($urandom), 0, 0);
        cs = 1; wr_en = 1; wr_data = 16'h1111;
        rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (st_std !== RST_ST || st_fwft !== RST_ST || s_rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_async: got %b/%b/%h expected %b/%b/0000", st_std, st_fwft, s_rd_data, RST_ST, RST_ST);
        end
        cs = 0; wr_en = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1, 1, 0, 16'h5A5A, 0, 0);
        step(1, 0, 1, '0, 0, 0);
        checks++;
        if (s_rd_data !== 16'h5A5A || s_empty !== 1'b1) begin
            failures++; $display("FAIL reset_first_word: got %h empty=%b expected 5a5a/1", s_rd_data, s_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_thresholds();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
